id1000500a_convolution: RTL and testbench

- AIP-compatible IP core that computes the 7-sample linear convolution of two 4-sample sequences.
- The host loads both sequences into an input memory, optionally configures a post-compute delay, pulses start, and is notified by an interrupt or a status poll.
- The host then reads the results from an output memory.
- All host access goes through the standard AIP config-bus read/write protocol.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_dpram.sv | 31 +++
 rtl/id1000500a_convolution.sv | 249 ++++++++++++++++++++++++
 tb/tb_id1000500a_convolution.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the 4x4-tap convolution core: register map,
// STATUS field layout, IP identifier and the sequencer state encoding.
package conv_pkg;

    localparam logic [4:0] AddrMdatain  = 5'd0;
    localparam logic [4:0] AddrAdatain  = 5'd1;
    localparam logic [4:0] AddrMdataout = 5'd2;
    localparam logic [4:0] AddrAdataout = 5'd3;
    localparam logic [4:0] AddrCdelay   = 5'd4;
    localparam logic [4:0] AddrAdelay   = 5'd5;
    localparam logic [4:0] AddrStatus   = 5'd30;
    localparam logic [4:0] AddrIpId     = 5'd31;

    localparam int unsigned StatusMaskMsb = 23;
    localparam int unsigned StatusMaskLsb = 16;
    localparam int unsigned StatusBusyBit = 8;
    localparam int unsigned StatusDoneBit = 0;

    localparam logic [31:0] IpIdValue = 32'h1000500A;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StDelay,
        StDone
    } conv_state_e;

    function automatic logic [31:0] status_word(input logic [7:0] mask,
                                                input logic       busy,
                                                input logic [7:0] flags);
        logic [31:0] w;
        w = '0;
        w[StatusMaskMsb:StatusMaskLsb] = mask;
        w[StatusBusyBit]               = busy;
        w[7:0]                         = flags;
        return w;
    endfunction

endpackage

// File: rtl/conv_dpram.sv
// Small RAM: one synchronous write port and NumRd registered read ports.
// Contents and read registers are deliberately not reset.
module conv_dpram #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 32,
    parameter int unsigned NumRd = 1,
    parameter int unsigned Aw    = $clog2(Depth)
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [Aw-1:0]               wr_addr,
    input  logic [Width-1:0]            wr_data,
    input  logic [NumRd-1:0]            rd_en,
    input  logic [NumRd-1:0][Aw-1:0]    rd_addr,
    output logic [NumRd-1:0][Width-1:0] rd_data
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        for (int i = 0; i < NumRd; i++) begin
            if (rd_en[i]) begin
                rd_data[i] <= mem[rd_addr[i]];
            end
        end
    end

endmodule

// File: rtl/id1000500a_convolution.sv
// AIP convolution core: z[n] = sum_k x[n-k]*h[k] over two 4-sample sequences,
// host access through the config bus, DONE interrupt with mask.
module id1000500a_convolution
    import conv_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = 32,
    parameter int unsigned MEM_SIZE    = 8,
    parameter int unsigned SEQ_LEN     = 4,
    parameter int unsigned CLKS_PER_MS = 50000,
    parameter logic [31:0] IP_ID_VALUE = IpIdValue
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic [DATAWIDTH-1:0] data_in,
    output logic [DATAWIDTH-1:0] data_out,
    input  logic                 write,
    input  logic                 read,
    input  logic                 start,
    input  logic [4:0]           conf_dbus,
    output logic                 int_req
);

    localparam int unsigned AW     = $clog2(MEM_SIZE);
    localparam int unsigned KW     = $clog2(SEQ_LEN);
    localparam int unsigned CntW   = AW + KW + 1;
    localparam int unsigned NPairs = MEM_SIZE * SEQ_LEN;
    localparam int unsigned CW     = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int unsigned MsW    = DATAWIDTH - 1;

    conv_state_e          state_q;
    logic                 busy_q;
    logic [CntW-1:0]      cnt_q;
    logic [DATAWIDTH-1:0] acc_q;
    logic                 p_vld_q;
    logic                 p_xok_q;
    logic [AW-1:0]        p_n_q;
    logic [KW-1:0]        p_k_q;
    logic [MsW-1:0]       ms_cnt_q;
    logic [CW-1:0]        clk_cnt_q;

    logic [AW-1:0]        ptr_in_q;
    logic [AW-1:0]        ptr_out_q;
    logic [7:0]           mask_q;
    logic                 done_q;
    logic [DATAWIDTH-1:0] cdelay_q;
    logic                 sel_mem_q;
    logic [DATAWIDTH-1:0] rdata_q;

    logic                 issue;
    logic [AW-1:0]        iss_n;
    logic [KW-1:0]        iss_k;
    logic [AW-1:0]        iss_x;
    logic                 iss_xok;
    logic                 p_last;
    logic                 delay_on;
    logic                 start_ok;
    logic [DATAWIDTH-1:0] prod;
    logic [DATAWIDTH-1:0] acc_sum;
    logic [7:0]           flags;
    logic [DATAWIDTH-1:0] reg_rdata;

    logic                          in_wr_en;
    logic [1:0]                    in_rd_en;
    logic [1:0][AW-1:0]            in_rd_addr;
    logic [1:0][DATAWIDTH-1:0]     in_rd_data;
    logic                          out_wr_en;
    logic                          out_rd_en;
    logic [DATAWIDTH-1:0]          out_rd_data;
    logic                          unused_rd_hi;

    // Issue stage: pair index cnt = {n, k}, k innermost.
    assign issue   = (state_q == StMac) && (cnt_q < CntW'(NPairs));
    assign iss_n   = cnt_q[AW+KW-1:KW];
    assign iss_k   = cnt_q[KW-1:0];
    assign iss_x   = iss_n - AW'(iss_k);
    assign iss_xok = (iss_n >= AW'(iss_k)) && (iss_x < AW'(SEQ_LEN));

    assign in_rd_en      = {2{en_s && issue}};
    assign in_rd_addr[0] = iss_x;
    assign in_rd_addr[1] = AW'(SEQ_LEN) + AW'(iss_k);

    // Accumulate stage, one cycle behind the operand reads.
    assign prod    = p_xok_q ? (DATAWIDTH'(in_rd_data[0][15:0]) * DATAWIDTH'(in_rd_data[1][15:0]))
                             : '0;
    assign acc_sum = acc_q + prod;
    assign p_last  = (p_n_q == AW'(MEM_SIZE - 1)) && (p_k_q == KW'(SEQ_LEN - 1));

    assign delay_on  = cdelay_q[0] && (cdelay_q[DATAWIDTH-1:1] != '0);
    assign start_ok  = (state_q == StIdle) && start;
    assign out_wr_en = en_s && p_vld_q && (p_k_q == KW'(SEQ_LEN - 1));
    assign in_wr_en  = en_s && write && (conf_dbus == AddrMdatain) && !busy_q;
    assign out_rd_en = en_s && read && (conf_dbus == AddrMdataout);

    assign flags    = {7'b0, done_q};
    assign int_req  = |(flags & mask_q);
    assign data_out = sel_mem_q ? out_rd_data : rdata_q;

    // Operands only use the low half-word.
    assign unused_rd_hi = ^{in_rd_data[0][DATAWIDTH-1:16], in_rd_data[1][DATAWIDTH-1:16]};

    conv_dpram #(
        .Depth (MEM_SIZE),
        .Width (DATAWIDTH),
        .NumRd (2)
    ) u_mem_in (
        .clk     (clk),
        .wr_en   (in_wr_en),
        .wr_addr (ptr_in_q),
        .wr_data (data_in),
        .rd_en   (in_rd_en),
        .rd_addr (in_rd_addr),
        .rd_data (in_rd_data)
    );

    conv_dpram #(
        .Depth (MEM_SIZE),
        .Width (DATAWIDTH),
        .NumRd (1)
    ) u_mem_out (
        .clk     (clk),
        .wr_en   (out_wr_en),
        .wr_addr (p_n_q),
        .wr_data (acc_sum),
        .rd_en   (out_rd_en),
        .rd_addr (ptr_out_q),
        .rd_data (out_rd_data)
    );

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            p_vld_q   <= 1'b0;
            p_xok_q   <= 1'b0;
            p_n_q     <= '0;
            p_k_q     <= '0;
            ms_cnt_q  <= '0;
            clk_cnt_q <= '0;
        end else if (en_s) begin
            p_vld_q <= issue;
            p_xok_q <= iss_xok;
            p_n_q   <= iss_n;
            p_k_q   <= iss_k;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    if (issue) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                    if (p_vld_q) begin
                        acc_q <= (p_k_q == KW'(SEQ_LEN - 1)) ? '0 : acc_sum;
                    end
                    if (p_vld_q && p_last) begin
                        if (delay_on) begin
                            ms_cnt_q  <= cdelay_q[DATAWIDTH-1:1];
                            clk_cnt_q <= '0;
                            state_q   <= StDelay;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StDelay: begin
                    if (clk_cnt_q == CW'(CLKS_PER_MS - 1)) begin
                        clk_cnt_q <= '0;
                        if (ms_cnt_q == MsW'(1)) begin
                            state_q <= StDone;
                        end else begin
                            ms_cnt_q <= ms_cnt_q - MsW'(1);
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (conf_dbus)
            AddrAdatain:  reg_rdata = DATAWIDTH'(ptr_in_q);
            AddrAdataout: reg_rdata = DATAWIDTH'(ptr_out_q);
            AddrCdelay:   reg_rdata = cdelay_q;
            AddrStatus:   reg_rdata = status_word(mask_q, busy_q, flags);
            AddrIpId:     reg_rdata = IP_ID_VALUE;
            default:      reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            ptr_in_q  <= '0;
            ptr_out_q <= '0;
            mask_q    <= '0;
            done_q    <= 1'b0;
            cdelay_q  <= '0;
            sel_mem_q <= 1'b0;
            rdata_q   <= '0;
        end else if (en_s) begin
            if (in_wr_en) begin
                ptr_in_q <= ptr_in_q + AW'(1);
            end
            if (write) begin
                case (conf_dbus)
                    AddrAdatain:  ptr_in_q  <= data_in[AW-1:0];
                    AddrAdataout: ptr_out_q <= data_in[AW-1:0];
                    AddrCdelay:   cdelay_q  <= data_in;
                    AddrStatus:   mask_q    <= data_in[StatusMaskMsb:StatusMaskLsb];
                    // Data ports are handled above; ADELAY accepts writes with no effect.
                    AddrMdatain, AddrMdataout, AddrAdelay: ;
                    default: ;
                endcase
            end
            if (out_rd_en) begin
                ptr_out_q <= ptr_out_q + AW'(1);
            end
            // Completion beats a same-cycle write-1-to-clear.
            if (state_q == StDone) begin
                done_q <= 1'b1;
            end else if (start_ok ||
                         (write && (conf_dbus == AddrStatus) && data_in[StatusDoneBit])) begin
                done_q <= 1'b0;
            end
            if (read) begin
                sel_mem_q <= (conf_dbus == AddrMdataout);
                if (conf_dbus != AddrMdataout) begin
                    rdata_q <= reg_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_id1000500a_convolution.sv
// Randomised self-checking bench for the convolution core against a plain
// arithmetic convolution model.
module tb_id1000500a_convolution;

    localparam int unsigned ClksPerMs = 10;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        en_s;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        write;
    logic        read;
    logic        start;
    logic [4:0]  conf_dbus;
    logic        int_req;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    logic [31:0] xw [4];
    logic [31:0] hw [4];
    logic [31:0] zm [8];
    logic [31:0] res [8];

    id1000500a_convolution #(
        .CLKS_PER_MS (ClksPerMs)
    ) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .en_s      (en_s),
        .data_in   (data_in),
        .data_out  (data_out),
        .write     (write),
        .read      (read),
        .start     (start),
        .conf_dbus (conf_dbus),
        .int_req   (int_req)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        conf_dbus = a;
        data_in   = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        conf_dbus = a;
        read      = 1'b1;
        tick();
        read      = 1'b0;
        d         = data_out;
    endtask

    task automatic load_ops();
        bus_write(5'd1, 32'd0);
        for (int i = 0; i < 4; i++) bus_write(5'd0, xw[i]);
        for (int i = 0; i < 4; i++) bus_write(5'd0, hw[i]);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < 4; i++) begin
            xw[i] = $urandom();
            hw[i] = $urandom();
        end
    endtask

    // Linear convolution of the low half-words, 32-bit wrap-around.
    task automatic model();
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 8; n++) begin
            zm[n] = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (n - k >= 0 && n - k < 4) begin
                    a = {16'd0, xw[n-k][15:0]};
                    b = {16'd0, hw[k][15:0]};
                    zm[n] = zm[n] + a * b;
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_int(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget && lat < 0; i++) begin
            if (int_req === 1'b1) lat = cyc - t0;
            else tick();
        end
    endtask

    task automatic read_results();
        bus_write(5'd3, 32'd0);
        for (int i = 0; i < 8; i++) bus_read(5'd2, res[i]);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_a = 1'b1; en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
        conf_dbus = 5'd0; data_in = 32'd0;
        repeat (3) tick();
        checks++;
        if (data_out !== 32'd0) begin
            errors++; $display("FAIL reset_data_out: got %h want %h", data_out, 32'd0);
        end
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL reset_int_req: got %b want 0", int_req);
        end
        rst_a = 1'b0;
        tick();
        bus_read(5'd31, d);
        checks++;
        if (d !== 32'h1000500A) begin
            errors++; $display("FAIL ip_id: got %h want %h", d, 32'h1000500A);
        end
        bus_read(5'd30, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h want %h", d, 32'h0);
        end
        bus_read(5'd7, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL unmapped_read: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_full_conv();
        logic [31:0] d;
        int lat;
        bus_write(5'd30, 32'h0001_0000);
        xw = '{32'd1, 32'd2, 32'd3, 32'd4};
        hw = '{32'd1, 32'd1, 32'd1, 32'd1};
        load_ops();
        bus_write(5'd4, 32'd0);
        model();
        pulse_start();
        wait_int(100, lat);
        checks++;
        if (lat != 34) begin
            errors++; $display("FAIL full_latency: got %0d want %0d", lat, 34);
        end
        bus_read(5'd30, d);
        checks++;
        if (d !== 32'h0001_0001) begin
            errors++; $display("FAIL full_status: got %h want %h", d, 32'h0001_0001);
        end
        read_results();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (res[i] !== zm[i]) begin
                errors++; $display("FAIL full_z[%0d]: got %h want %h", i, res[i], zm[i]);
            end
        end
    endtask

    task automatic test_int_clear();
        logic [31:0] d;
        bus_write(5'd30, 32'h0001_0001);
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL clear_int_req: got %b want 0", int_req);
        end
        bus_read(5'd30, d);
        checks++;
        if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL clear_status: got %h want %h", d, 32'h0001_0000);
        end
        bus_write(5'd30, 32'h0000_0000);
        pulse_start();
        repeat (40) tick();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL masked_int_req: got %b want 0", int_req);
        end
        bus_read(5'd30, d);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++; $display("FAIL masked_status: got %h want %h", d, 32'h0000_0001);
        end
        bus_write(5'd30, 32'h0001_0000);
        checks++;
        if (int_req !== 1'b1) begin
            errors++; $display("FAIL unmask_int_req: got %b want 1", int_req);
        end
        bus_write(5'd30, 32'h0001_0001);
    endtask

    task automatic test_random();
        int lat;
        for (int r = 0; r < 4; r++) begin
            randomize_ops();
            load_ops();
            model();
            pulse_start();
            wait_int(100, lat);
            checks++;
            if (lat != 34) begin
                errors++; $display("FAIL rand%0d_latency: got %0d want %0d", r, lat, 34);
            end
            read_results();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (res[i] !== zm[i]) begin
                    errors++; $display("FAIL rand%0d_z[%0d]: got %h want %h", r, i, res[i], zm[i]);
                end
            end
            bus_write(5'd30, 32'h0001_0001);
        end
    endtask

    task automatic test_back_to_back_busy();
        logic [31:0] d;
        int lat;
        randomize_ops();
        load_ops();
        model();
        pulse_start();
        tick();
        bus_read(5'd30, d);
        checks++;
        if (d !== 32'h0001_0100) begin
            errors++; $display("FAIL busy_status: got %h want %h", d, 32'h0001_0100);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        bus_write(5'd1, 32'd0);
        bus_write(5'd0, 32'hDEAD_BEEF);
        bus_write(5'd0, 32'h1234_5678);
        wait_int(100, lat);
        checks++;
        if (lat != 34) begin
            errors++; $display("FAIL busy_latency: got %0d want %0d", lat, 34);
        end
        bus_read(5'd30, d);
        checks++;
        if (d !== 32'h0001_0001) begin
            errors++; $display("FAIL busy_done_status: got %h want %h", d, 32'h0001_0001);
        end
        read_results();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (res[i] !== zm[i]) begin
                errors++; $display("FAIL busy_z[%0d]: got %h want %h", i, res[i], zm[i]);
            end
        end
        // Rerun on untouched input memory: ignored writes must not have landed.
        bus_write(5'd30, 32'h0001_0001);
        pulse_start();
        wait_int(100, lat);
        read_results();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (res[i] !== zm[i]) begin
                errors++; $display("FAIL rerun_z[%0d]: got %h want %h", i, res[i], zm[i]);
            end
        end
        bus_write(5'd30, 32'h0001_0001);
    endtask

    task automatic test_delay();
        logic [31:0] d;
        int lat;
        int dly_val [3] = '{5, 1, 4};
        int dly_lat [3] = '{34 + 2 * ClksPerMs, 34, 34};
        for (int j = 0; j < 3; j++) begin
            bus_write(5'd4, dly_val[j]);
            bus_read(5'd4, d);
            checks++;
            if (d !== 32'(dly_val[j])) begin
                errors++; $display("FAIL cdelay_rb%0d: got %h want %h", j, d, dly_val[j]);
            end
            pulse_start();
            wait_int(200, lat);
            checks++;
            if (lat != dly_lat[j]) begin
                errors++; $display("FAIL delay%0d_latency: got %0d want %0d", j, lat, dly_lat[j]);
            end
            bus_write(5'd30, 32'h0001_0001);
        end
        bus_write(5'd4, 32'd0);
    endtask

    task automatic test_limits();
        int lat;
        for (int i = 0; i < 4; i++) begin
            xw[i] = 32'h0000_FFFF;
            hw[i] = 32'hA5A5_FFFF;
        end
        load_ops();
        model();
        pulse_start();
        wait_int(100, lat);
        read_results();
        checks++;
        if (res[3] !== 32'hFFF8_0004) begin
            errors++; $display("FAIL limit_z3: got %h want %h", res[3], 32'hFFF8_0004);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (res[i] !== zm[i]) begin
                errors++; $display("FAIL limit_z[%0d]: got %h want %h", i, res[i], zm[i]);
            end
        end
        bus_write(5'd30, 32'h0001_0001);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        pulse_start();
        repeat (5) tick();
        bus_read(5'd30, d);
        checks++;
        if (d !== 32'h0001_0100) begin
            errors++; $display("FAIL pre_reset_status: got %h want %h", d, 32'h0001_0100);
        end
        #2 rst_a = 1'b1;
        #1;
        checks++;
        if (data_out !== 32'd0) begin
            errors++; $display("FAIL mid_reset_data_out: got %h want %h", data_out, 32'd0);
        end
        tick();
        rst_a = 1'b0;
        repeat (40) tick();
        checks++;
        if (int_req !== 1'b0) begin
            errors++; $display("FAIL mid_reset_int_req: got %b want 0", int_req);
        end
        bus_read(5'd30, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL mid_reset_status: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_enable();
        int lat;
        bus_write(5'd30, 32'h0001_0000);
        randomize_ops();
        load_ops();
        model();
        pulse_start();
        repeat (10) tick();
        en_s = 1'b0;
        // Mask write while disabled must be dropped.
        bus_write(5'd30, 32'h0000_0000);
        repeat (4) tick();
        en_s = 1'b1;
        wait_int(100, lat);
        checks++;
        if (lat != 39) begin
            errors++; $display("FAIL enable_latency: got %0d want %0d", lat, 39);
        end
        read_results();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (res[i] !== zm[i]) begin
                errors++; $display("FAIL enable_z[%0d]: got %h want %h", i, res[i], zm[i]);
            end
        end
        bus_write(5'd30, 32'h0001_0001);
    endtask

    initial begin
        test_reset();
        test_full_conv();
        test_int_clear();
        test_random();
        test_back_to_back_busy();
        test_delay();
        test_limits();
        test_reset_mid();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
